// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU result reporter: frame layout, FSM states and
// the byte selector used to serialise a snapshot.
package cpu_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;
    localparam int         FRAME_LEN    = 9;
    localparam int         IDX_W        = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_COUNT  = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Frame is header, PC, ACC, cycle count; every field goes out MSB first.
    function automatic logic [7:0] frame_byte(
        input logic [IDX_W-1:0] idx,
        input logic [15:0]      pc,
        input logic [15:0]      acc,
        input logic [31:0]      cycles
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = FRAME_HEADER;
            4'd1:    b = pc[15:8];
            4'd2:    b = pc[7:0];
            4'd3:    b = acc[15:8];
            4'd4:    b = acc[7:0];
            4'd5:    b = cycles[31:24];
            4'd6:    b = cycles[23:16];
            4'd7:    b = cycles[15:8];
            4'd8:    b = cycles[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cycle_counter.sv
// Saturating up counter with enable; asynchronous active-low clear to RESET_VALUE.
module cycle_counter #(
    parameter int                    NB_CYCLES   = 32,
    parameter logic [NB_CYCLES-1:0]  RESET_VALUE = '0
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    output logic [NB_CYCLES-1:0] o_count
);

    logic [NB_CYCLES-1:0] r_count;

    // Holds at all-ones so a very long run reports the maximum rather than wrapping.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_count <= RESET_VALUE;
        end else if (i_enable && (r_count != '1)) begin
            r_count <= r_count + NB_CYCLES'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cpu_result_reporter.sv
// Snapshots PC, accumulator and elapsed cycles when the CPU halts, then sends
// them to the UART transmitter as a 9-byte frame using a start/done handshake.
module cpu_result_reporter
    import cpu_pkg::*;
#(
    parameter int                   NB_ADDR         = 11,
    parameter int                   NB_DATA         = 16,
    parameter int                   NB_CYCLES       = 32,
    parameter int                   NB_BYTE         = 8,
    parameter logic [NB_CYCLES-1:0] CNT_RESET_VALUE = '0
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_halt,
    input  logic [NB_ADDR-1:0] i_pc,
    input  logic [NB_DATA-1:0] i_acc,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_busy,
    output logic               o_done
);

    state_t               r_state;
    state_t               w_next_state;
    logic [IDX_W-1:0]     r_idx;
    logic [NB_ADDR-1:0]   r_pc;
    logic [NB_DATA-1:0]   r_acc;
    logic [NB_CYCLES-1:0] r_cycles;
    logic [NB_CYCLES-1:0] w_count;
    logic                 w_count_en;
    logic                 w_capture;
    logic                 w_advance;

    // The halt edge itself is not counted, and counting stops for good once captured.
    assign w_count_en = (r_state == ST_COUNT) && !i_halt;

    cycle_counter #(
        .NB_CYCLES   (NB_CYCLES),
        .RESET_VALUE (CNT_RESET_VALUE)
    ) u_cycle_counter (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_enable (w_count_en),
        .o_count  (w_count)
    );

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_COUNT: begin
                if (i_halt) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_next_state = ST_FINISH;
                    end else begin
                        w_advance    = 1'b1;
                        w_next_state = ST_SEND;
                    end
                end
            end
            ST_FINISH: begin
                w_next_state = ST_FINISH;
            end
            default: begin
                w_next_state = ST_COUNT;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_COUNT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Snapshot is written once; later PC/ACC activity cannot reach the frame.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_pc     <= '0;
            r_acc    <= '0;
            r_cycles <= '0;
        end else if (w_capture) begin
            r_pc     <= i_pc;
            r_acc    <= i_acc;
            r_cycles <= w_count;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_idx <= '0;
        end else if (w_capture) begin
            r_idx <= '0;
        end else if (w_advance) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Data follows the byte index, so it stays stable through WAIT and after the last byte.
    always_comb begin
        o_tx_start = (r_state == ST_SEND);
        o_busy     = (r_state == ST_SEND) || (r_state == ST_WAIT);
        o_done     = (r_state == ST_FINISH);
        if (r_state == ST_COUNT) begin
            o_tx_data = '0;
        end else begin
            o_tx_data = NB_BYTE'(frame_byte(r_idx, 16'(r_pc), 16'(r_acc), 32'(r_cycles)));
        end
    end

endmodule
